// File: rtl/rotor_stepper_if.sv
// Key-press, load and rotor-position signals shared by the rotor stepper
// and whoever drives it.
interface rotor_stepper_if;
    logic        STEP_REQ;
    logic        LOAD;
    logic [4:0]  POS_INIT_L;
    logic [4:0]  POS_INIT_M;
    logic [4:0]  POS_INIT_R;
    logic [4:0]  POS_L;
    logic [4:0]  POS_M;
    logic [4:0]  POS_R;
    logic        READY;
    logic        POS_VALID;
    logic        STEP_DONE;
    logic        OVERRUN;
    logic        NOTCH_HIT_L;
    logic [15:0] STEP_COUNT;

    modport master (
        output STEP_REQ, LOAD, POS_INIT_L, POS_INIT_M, POS_INIT_R,
        input  POS_L, POS_M, POS_R, READY, POS_VALID, STEP_DONE, OVERRUN,
        input  NOTCH_HIT_L, STEP_COUNT
    );

    modport slave (
        input  STEP_REQ, LOAD, POS_INIT_L, POS_INIT_M, POS_INIT_R,
        output POS_L, POS_M, POS_R, READY, POS_VALID, STEP_DONE, OVERRUN,
        output NOTCH_HIT_L, STEP_COUNT
    );
endinterface

// File: rtl/rotor_stepper.sv
// Enigma rotor-position controller: odometer stepping with the middle-rotor
// double step, followed by a settle window before positions are valid again.
module rotor_stepper #(
    parameter int NOTCH_R       = 21,
    parameter int NOTCH_M       = 4,
    parameter int NOTCH_L       = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    rotor_stepper_if.slave   bus
);
    localparam int         CW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [4:0] NOTCH_R_V   = 5'(NOTCH_R);
    localparam logic [4:0] NOTCH_M_V   = 5'(NOTCH_M);
    localparam logic [4:0] NOTCH_L_V   = 5'(NOTCH_L);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    pos_l_q, pos_l_d;
    logic [4:0]    pos_m_q, pos_m_d;
    logic [4:0]    pos_r_q, pos_r_d;
    logic [15:0]   count_q, count_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;

    function automatic logic [4:0] inc_pos(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    // Init values 26..31 fold back into range so positions stay 0..25.
    function automatic logic [4:0] fold_pos(input logic [4:0] p);
        return (p >= 5'd26) ? p - 5'd26 : p;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pos_l_d   = pos_l_q;
        pos_m_d   = pos_m_q;
        pos_r_d   = pos_r_q;
        count_d   = count_q;
        ready_d   = ready_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (bus.LOAD) begin
                    pos_l_d   = fold_pos(bus.POS_INIT_L);
                    pos_m_d   = fold_pos(bus.POS_INIT_M);
                    pos_r_d   = fold_pos(bus.POS_INIT_R);
                    count_d   = 16'd0;
                    overrun_d = 1'b0;
                end else if (bus.STEP_REQ) begin
                    // A middle rotor sitting on its notch drags itself along too.
                    pos_r_d = inc_pos(pos_r_q);
                    if (pos_r_q == NOTCH_R_V || pos_m_q == NOTCH_M_V)
                        pos_m_d = inc_pos(pos_m_q);
                    if (pos_m_q == NOTCH_M_V)
                        pos_l_d = inc_pos(pos_l_q);
                    count_d = count_q + 16'd1;
                    state_d = SETTLE;
                    cnt_d   = SETTLE_INIT;
                    ready_d = 1'b0;
                    valid_d = 1'b0;
                end
            end
            SETTLE: begin
                if (bus.STEP_REQ)
                    overrun_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pos_l_q   <= 5'd0;
            pos_m_q   <= 5'd0;
            pos_r_q   <= 5'd0;
            count_q   <= 16'd0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_l_q   <= pos_l_d;
            pos_m_q   <= pos_m_d;
            pos_r_q   <= pos_r_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.POS_L       = pos_l_q;
    assign bus.POS_M       = pos_m_q;
    assign bus.POS_R       = pos_r_q;
    assign bus.READY       = ready_q;
    assign bus.POS_VALID   = valid_q;
    assign bus.STEP_DONE   = done_q;
    assign bus.OVERRUN     = overrun_q;
    assign bus.STEP_COUNT  = count_q;
    assign bus.NOTCH_HIT_L = (pos_l_q == NOTCH_L_V);
endmodule
